// File: rtl/simple_echo_pkg.sv
// Shared definitions for simple_echo: receive-FSM encodings and the layout of
// one buffer entry {tlast, tstrb, tdata}.
package simple_echo_pkg;

    typedef enum logic {
        RX_ACCEPT = 1'b0,
        RX_DROP   = 1'b1
    } rx_state_e;

    localparam int unsigned TDATA_LSB = 0;

    function automatic int unsigned tstrb_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned tlast_bit(input int unsigned dw);
        return dw + dw / 8;
    endfunction

    function automatic int unsigned entry_width(input int unsigned dw);
        return dw + dw / 8 + 1;
    endfunction

endpackage

// File: rtl/simple_echo_buf.sv
// Packet storage for simple_echo: 2^C_BUF_AW entries, synchronous write port and
// combinational read port.
module simple_echo_buf #(
    parameter int unsigned C_BUF_AW  = 5,
    parameter int unsigned C_ENTRY_W = 73
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [C_BUF_AW-1:0]  i_wr_addr,
    input  logic [C_ENTRY_W-1:0] i_wr_data,
    input  logic [C_BUF_AW-1:0]  i_rd_addr,
    output logic [C_ENTRY_W-1:0] o_rd_data
);

    logic [C_ENTRY_W-1:0] r_mem [2**C_BUF_AW];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/simple_echo.sv
// Store-and-forward AXI4-Stream echo: buffers whole packets, replays committed ones.
// Optional SIMPLE_ECHO_BACKPRESSURE_EN holds off the slave stream instead of dropping.
module simple_echo
    import simple_echo_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH = 64,
    parameter int unsigned C_S_AXIS_DATA_WIDTH = 64,
    parameter int unsigned C_BUF_AW            = 5,
    parameter int unsigned C_CNT_WIDTH         = 32
) (
    input  logic                             axi_aclk,
    input  logic                             axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    input  logic                             count_reset,
    output logic [C_CNT_WIDTH-1:0]           echo_count,
    output logic [C_CNT_WIDTH-1:0]           drop_count
);

    localparam int unsigned DW       = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned EW       = entry_width(DW);
    localparam int unsigned STRB_LSB = tstrb_lsb(DW);
    localparam int unsigned LAST_BIT = tlast_bit(DW);
    localparam logic [C_BUF_AW:0] FULL_DIFF = {1'b1, {C_BUF_AW{1'b0}}};

    rx_state_e r_state, w_state_next;

    logic [C_BUF_AW:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [C_BUF_AW:0] w_wr_ptr_next, w_cmt_ptr_next, w_rd_ptr_next;

    logic w_full, w_in_hs, w_wr_en, w_rewind, w_commit, w_drop_inc, w_load, w_echo_inc;
    logic [EW-1:0] w_wr_entry, w_rd_entry;

    logic                             r_m_tvalid, r_m_tlast;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   r_m_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] r_m_tstrb;
    logic [C_CNT_WIDTH-1:0]           r_echo_count, r_drop_count;

    assign w_full  = (r_wr_ptr - r_rd_ptr) == FULL_DIFF;
    assign w_in_hs = s_axis_tvalid && s_axis_tready;

`ifdef SIMPLE_ECHO_BACKPRESSURE_EN
    logic r_s_tready;

    // Computed from next-state pointers so the registered ready matches the live pointers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_s_tready <= 1'b1;
        end else begin
            r_s_tready <= ((w_wr_ptr_next - w_rd_ptr_next) != FULL_DIFF) ||
                          (w_rd_ptr_next == w_cmt_ptr_next);
        end
    end

    assign s_axis_tready = r_s_tready;
`else
    assign s_axis_tready = 1'b1;
`endif

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= RX_ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_ACCEPT: begin
                if (w_in_hs && w_full && !s_axis_tlast) begin
                    w_state_next = RX_DROP;
                end
            end
            RX_DROP: begin
                if (w_in_hs && s_axis_tlast) begin
                    w_state_next = RX_ACCEPT;
                end
            end
            default: w_state_next = RX_ACCEPT;
        endcase
    end

    always_comb begin
        w_wr_en    = 1'b0;
        w_rewind   = 1'b0;
        w_commit   = 1'b0;
        w_drop_inc = 1'b0;
        case (r_state)
            RX_ACCEPT: begin
                if (w_in_hs) begin
                    if (!w_full) begin
                        w_wr_en  = 1'b1;
                        w_commit = s_axis_tlast;
                    end else begin
                        w_rewind   = 1'b1;
                        w_drop_inc = s_axis_tlast;
                    end
                end
            end
            RX_DROP: begin
                w_drop_inc = w_in_hs && s_axis_tlast;
            end
            default: ;
        endcase
    end

    assign w_load     = (r_rd_ptr != r_cmt_ptr) && (!r_m_tvalid || m_axis_tready);
    assign w_echo_inc = r_m_tvalid && m_axis_tready && r_m_tlast;

    always_comb begin
        w_wr_ptr_next  = r_wr_ptr;
        w_cmt_ptr_next = r_cmt_ptr;
        w_rd_ptr_next  = r_rd_ptr;
        if (w_wr_en) begin
            w_wr_ptr_next = r_wr_ptr + 1'b1;
        end
        if (w_rewind) begin
            w_wr_ptr_next = r_cmt_ptr;
        end
        if (w_commit) begin
            w_cmt_ptr_next = r_wr_ptr + 1'b1;
        end
        if (w_load) begin
            w_rd_ptr_next = r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_next;
            r_cmt_ptr <= w_cmt_ptr_next;
            r_rd_ptr  <= w_rd_ptr_next;
        end
    end

    assign w_wr_entry = {s_axis_tlast, s_axis_tstrb, s_axis_tdata};

    simple_echo_buf #(
        .C_BUF_AW  (C_BUF_AW),
        .C_ENTRY_W (EW)
    ) u_buf (
        .i_clk     (axi_aclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[C_BUF_AW-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr[C_BUF_AW-1:0]),
        .o_rd_data (w_rd_entry)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_rd_entry[TDATA_LSB +: DW];
            r_m_tstrb  <= w_rd_entry[STRB_LSB +: SW];
            r_m_tlast  <= w_rd_entry[LAST_BIT];
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_echo_count <= '0;
            r_drop_count <= '0;
        end else if (count_reset) begin
            r_echo_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_echo_inc) begin
                r_echo_count <= r_echo_count + 1'b1;
            end
            if (w_drop_inc) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tstrb  = r_m_tstrb;
    assign echo_count    = r_echo_count;
    assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_simple_echo.sv
// Self-checking bench for simple_echo: directed cases plus randomized packets
// scored against a packet-level reference queue.
module tb_simple_echo;

    localparam int unsigned DW    = 64;
    localparam int unsigned SW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned EW    = DW + SW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tstrb = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          count_reset = 1'b0;
    logic [CW-1:0] echo_count;
    logic [CW-1:0] drop_count;

    simple_echo #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_BUF_AW            (AW),
        .C_CNT_WIDTH         (CW)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .count_reset   (count_reset),
        .echo_count    (echo_count),
        .drop_count    (drop_count)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: flat queue of expected output beats plus expected counters.
    logic [EW-1:0] exp_q[$];
    int            exp_echo = 0;
    int            exp_drop = 0;
    int            rdy_mode = 0;
    int            run_len  = 0;
    int            max_run  = 0;
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_beat  = '0;
    logic [EW-1:0] mon_cur;
    logic [EW-1:0] mon_exp;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: sampled on the falling edge, between active edges.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            mon_cur = {m_tlast, m_tstrb, m_tdata};
            if (prev_stall) begin
                check_eq("hold", {m_tvalid, mon_cur}, {1'b1, prev_beat});
            end
            if (m_tvalid && m_tready) begin
                check_eq("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check_eq("beat", mon_cur, mon_exp);
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = mon_cur;
        end
    end

    task automatic drive_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int   tries;
        logic acc;
        tries    = 0;
        acc      = 1'b0;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 200);
        if (!acc) check_eq("in_accept_timeout", acc, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Bench assumes the buffer is drained (or only holds small back-to-back packets)
    // when a packet starts, so a packet is echoed iff it fits the buffer.
    task automatic send_pkt(input int len, input int gap_max, input bit rot);
        logic [EW-1:0] beats[$];
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
        d = 64'hCAFEBEEFCAFEBEEF;
        s = '1;
        for (int i = 0; i < len; i++) begin
            if (!rot) begin
                d = {$urandom, $urandom};
                s = SW'($urandom);
            end
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            l = (i == len - 1);
            drive_beat(d, s, l);
            beats.push_back({l, s, d});
            if (rot) d = {d[0], d[DW-1:1]};
        end
        if (len <= int'(DEPTH)) begin
            foreach (beats[k]) exp_q.push_back(beats[k]);
            exp_echo++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", (exp_q.size() == 0) && !m_tvalid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_echo_count"}, echo_count, exp_echo);
        check_eq({tag, "_drop_count"}, drop_count, exp_drop);
    endtask

    task automatic check_reset_state();
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_m_tlast", m_tlast, 0);
        check_eq("rst_m_tdata", m_tdata, 0);
        check_eq("rst_m_tstrb", m_tstrb, 0);
        check_eq("rst_echo_count", echo_count, 0);
        check_eq("rst_drop_count", drop_count, 0);
        check_eq("rst_s_tready", s_tready, 1);
    endtask

    initial begin
        int len;
        int grp;
        int found;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // 16-word rotated packet, ready held high, latency from the tlast edge.
        rdy_mode = 0;
        send_pkt(16, 0, 1'b1);
        @(negedge clk);
        check_eq("lat_pre", m_tvalid, 0);
        @(negedge clk);
        check_eq("lat_first", m_tvalid, 1);
        @(posedge clk);
        #1;
        wait_drain();
        check_counts("t1");

        // Same packet with downstream ready toggling.
        rdy_mode = 1;
        send_pkt(16, 0, 1'b1);
        wait_drain();
        check_counts("t2");

        // Three back-to-back 8-word packets leave as one contiguous burst.
        rdy_mode = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        max_run = 0;
        repeat (3) send_pkt(8, 0, 1'b0);
        wait_drain();
        check_eq("b2b_run", max_run, 24);
        check_counts("t3");

        // Oversized packet dropped, following small packet still echoed.
        send_pkt(40, 0, 1'b0);
        wait_drain();
        check_counts("t4_drop");
        send_pkt(4, 0, 1'b0);
        wait_drain();
        check_counts("t4_after");

        // Boundary sizes: exactly full fits, one over is dropped on its tlast beat.
        send_pkt(int'(DEPTH), 1, 1'b0);
        wait_drain();
        send_pkt(int'(DEPTH) + 1, 1, 1'b0);
        wait_drain();
        check_counts("t4_edge");

        // count_reset coincident with an echoed tlast: clear wins.
        send_pkt(4, 0, 1'b0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (m_tvalid && m_tready && m_tlast) found = 1;
        end
        check_eq("cr_found_tlast", found, 1);
        count_reset = 1'b1;
        @(posedge clk);
        #1;
        count_reset = 1'b0;
        exp_echo = 0;
        exp_drop = 0;
        check_counts("t5");
        wait_drain();
        check_counts("t5_after");

        // Reset in the middle of a 16-word receive.
        for (int i = 0; i < 8; i++) begin
            drive_beat({$urandom, $urandom}, SW'($urandom), 1'b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_echo = 0;
        exp_drop = 0;
        send_pkt(16, 0, 1'b0);
        wait_drain();
        check_counts("t6");

        // Randomized single packets with gaps and random downstream ready.
        rdy_mode = 2;
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 5))
                0:       len = int'(DEPTH);
                1:       len = int'(DEPTH) + 1;
                default: len = int'($urandom_range(1, 40));
            endcase
            send_pkt(len, 2, 1'b0);
            wait_drain();
        end
        check_counts("rand_single");

        // Randomized back-to-back groups that together still fit the buffer.
        for (int n = 0; n < 8; n++) begin
            grp = int'($urandom_range(2, 4));
            for (int k = 0; k < grp; k++) begin
                send_pkt(int'($urandom_range(1, 8)), 0, 1'b0);
            end
            wait_drain();
            check_counts("rand_group");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures",
                 n_checks, n_fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simple_echo.md
# simple_echo

Store-and-forward AXI4-Stream loopback responder; it is the far end of the pattern-generator/checker link. It accepts complete packets on its slave stream, buffers each one until its `tlast` beat arrives, then replays it unchanged on its master stream. This closes the loop from the generator's transmit port back to its checker. Packets that cannot fit in the buffer are discarded whole, and the block keeps echoed-packet and dropped-packet counts for status readout.

## Interface
Parameters:
- `C_M_AXIS_DATA_WIDTH`, 64: master stream data width; must equal `C_S_AXIS_DATA_WIDTH`.
- `C_S_AXIS_DATA_WIDTH`, 64: slave stream data width.
- `C_BUF_AW`, 5: log2 of buffer depth in words (default 32 words).
- `C_CNT_WIDTH`, 32: width of status counters.

Ports:
- `axi_aclk` in 1: single clock for all logic.
- `axi_aresetn` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in `C_S_AXIS_DATA_WIDTH`: inbound data.
- `s_axis_tstrb` in `C_S_AXIS_DATA_WIDTH/8`: inbound byte strobes; stored and echoed.
- `s_axis_tvalid` in 1: inbound beat valid.
- `s_axis_tready` out 1: inbound ready.
- `s_axis_tlast` in 1: inbound end of packet.
- `m_axis_tdata` out `C_M_AXIS_DATA_WIDTH`: echoed data.
- `m_axis_tstrb` out `C_M_AXIS_DATA_WIDTH/8`: echoed strobes.
- `m_axis_tvalid` out 1: echoed beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: echoed end of packet.
- `count_reset` in 1: synchronous clear of both counters.
- `echo_count` out `C_CNT_WIDTH`: packets fully echoed.
- `drop_count` out `C_CNT_WIDTH`: packets discarded.

## Operation
- Buffer geometry:
  - Circular buffer of 2^`C_BUF_AW` entries; each entry holds {tlast, tstrb, tdata}.
  - Pointers `wr_ptr`, `cmt_ptr` and `rd_ptr` are each `C_BUF_AW`+1 bits wide; the extra MSB distinguishes full from empty.
  - Full: `wr_ptr - rd_ptr == 2^C_BUF_AW`.
- Receive FSM, state RX_ACCEPT (the reset state):
  - A valid beat with the buffer not full is written at `wr_ptr`, and `wr_ptr` increments.
  - If that beat has `tlast`, then `cmt_ptr <= wr_ptr+1`.
  - A valid beat arriving while full rewinds `wr_ptr <= cmt_ptr`. If the beat is `tlast`, `drop_count` increments and the FSM stays in RX_ACCEPT; otherwise it moves to RX_DROP.
- Receive FSM, state RX_DROP:
  - Valid beats are discarded.
  - A valid `tlast` beat increments `drop_count` and returns to RX_ACCEPT.
- Transmit side:
  - The output register loads the entry at `rd_ptr` whenever `rd_ptr != cmt_ptr` and (`!m_axis_tvalid || m_axis_tready`); `rd_ptr` increments on each load.
  - `m_axis_tvalid` deasserts when the current beat is taken and no committed entry remains.
  - Output data, strobes and `tlast` hold stable while `m_axis_tvalid && !m_axis_tready`.
- Only committed words are ever transmitted, so a partial or dropped packet never appears on the master stream.
- `echo_count` increments on every master beat with `m_axis_tvalid && m_axis_tready && m_axis_tlast`.
- Counters wrap modulo 2^`C_CNT_WIDTH`. When `count_reset` and an increment occur in the same cycle, the reset wins and the counter reads 0.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tstrb`: 0.
  - All pointers: 0. Both counters: 0. State: RX_ACCEPT.
  - `s_axis_tready`: 1 without the macro; 1 with the macro, because the buffer is empty.
- Reset asserted mid-packet discards all buffered and partial content; the block restarts empty.

## Timing
- Latency: the `tlast` beat is accepted at edge E, which updates `cmt_ptr`. The first word of that packet is loaded at edge E+1, so `m_axis_tvalid` is high in the cycle after E+1.
- Throughput: one beat per cycle in each direction, concurrently. Transmit of packet N overlaps receive of packet N+1.
- Back-to-back committed packets are emitted with no idle cycle between them.
- A packet longer than 2^`C_BUF_AW` words is always dropped.

## Configuration
- `SIMPLE_ECHO_BACKPRESSURE_EN` defined:
  - `s_axis_tready = !full || (rd_ptr == cmt_ptr)`, registered from the pointers.
  - Packets that fit are never dropped.
  - Full with no committed data, i.e. the packet is oversized, keeps ready high and drops through the path above.
- Not defined:
  - `s_axis_tready` is tied to 1.
  - Any packet meeting a full buffer is dropped.

## Structure
- Package `simple_echo_pkg`: RX state encodings (RX_ACCEPT=1'b0, RX_DROP=1'b1) and the entry-layout offsets for the tlast, tstrb and tdata fields.
- Sub-module `simple_echo_buf`: the storage array with write port and combinational read port, parameterised by `C_BUF_AW` and entry width.
- Pointer, FSM, output-register and counter logic stay in the top module.

## Test plan
- Single 16-word packet, words 0xCAFEBEEFCAFEBEEF rotated right by 1 per word, `m_axis_tready`=1 -> identical 16 words out, `tlast` on word 16, first valid 2 cycles after input `tlast`, `echo_count`=1.
- Same packet with `m_axis_tready` toggling 1/0 each cycle -> output stable while stalled, all 16 words delivered in order, `echo_count`=1.
- Three back-to-back 8-word packets -> 24 contiguous output beats, `echo_count`=3, `drop_count`=0.
- 40-word packet, `C_BUF_AW`=5 -> no output, `drop_count`=1; a following 4-word packet is echoed correctly.
- `count_reset` pulsed in the same cycle as an echoed `tlast` -> `echo_count`=0 the next cycle.
- `axi_aresetn` low for 2 cycles midway through a 16-word receive -> all outputs 0, counters 0; the next full packet echoes correctly.
